// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Register-hazard scoreboard for an in-order pipeline. It tracks outstanding
// writes from multi-cycle units and tells the ID stage when to stall.
//
// Each tracked register has two pieces of state:
//   - a fixed-latency countdown, loaded with the issue latency and run down to 0
//   - a variable-latency flag, set on a latency-0 issue and cleared by iDone
// A single variable-latency unit is modelled, so a second variable issue is
// stalled until the unit reports completion.
//
// Ports
//   iCLK, iRST_n          clock (rising edge), asynchronous active-low reset
//   iID_Rs1/iID_Rs2       ID-stage source registers
//   iID_UseRs1/UseRs2     the ID instruction actually reads that source
//   iID_Rd                ID-stage destination register
//   iIssue, iIssue_Lat    multi-cycle issue request and its latency (0 = variable)
//   iDone, iDone_Rd       variable-latency unit writes iDone_Rd this cycle
//   iFlush                exception/pipeline flush, drops all outstanding entries
//   oStall                combinational stall request to ID
//   oPending              per-register outstanding-write vector (bit 0 always 0)
//   oUnitBusy             variable-latency unit has an operation in flight
//   oStallCount           saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int RW   = 5,
    parameter int LATW = 5,
    parameter int CNTW = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [RW-1:0]     iID_Rs1,
    input  logic [RW-1:0]     iID_Rs2,
    input  logic              iID_UseRs1,
    input  logic              iID_UseRs2,
    input  logic [RW-1:0]     iID_Rd,
    input  logic              iIssue,
    input  logic [LATW-1:0]   iIssue_Lat,
    input  logic              iDone,
    input  logic [RW-1:0]     iDone_Rd,
    input  logic              iFlush,
    output logic              oStall,
    output logic [NREG-1:0]   oPending,
    output logic              oUnitBusy,
    output logic [CNTW-1:0]   oStallCount
);

    logic [LATW-1:0] cnt_r [NREG];
    logic [NREG-1:0] var_r;
    logic            busy_r;
    logic [CNTW-1:0] stallCount_r;

    logic [LATW-1:0] cntNext_s [NREG];
    logic [NREG-1:0] varNext_s;
    logic            busyNext_s;
    logic [NREG-1:0] pending_s;
    logic            stall_s;
    logic            accept_s;
    logic            acceptFix_s;
    logic            acceptVar_s;
    logic            doneValid_s;

    // Look up a pending bit; indices beyond NREG are never pending.
    function automatic logic pendingAt(input logic [NREG-1:0] vec, input logic [RW-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(idx) == k) begin
                hit = vec[k];
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Pending vector derived from countdown and variable-latency flag.
    always_comb begin
        pending_s = {NREG{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            pending_s[r] = (cnt_r[r] != {LATW{1'b0}}) | var_r[r];
        end
    end

    // Stall terms: RAW on either source, WAW on the destination, and the
    // structural hazard on the single variable-latency unit. A completing
    // unit frees itself in the same cycle, so iDone lifts the structural term.
    always_comb begin
        stall_s = (iID_UseRs1 & pendingAt(pending_s, iID_Rs1))
                | (iID_UseRs2 & pendingAt(pending_s, iID_Rs2))
                | (iIssue & (iID_Rd != {RW{1'b0}}) & pendingAt(pending_s, iID_Rd))
                | (iIssue & (iIssue_Lat == {LATW{1'b0}}) & busy_r & ~iDone);
    end

    // Issue acceptance qualifiers; flush blocks acceptance but not the stall.
    always_comb begin
        accept_s    = iIssue & ~stall_s & ~iFlush;
        acceptFix_s = accept_s & (iIssue_Lat != {LATW{1'b0}});
        acceptVar_s = accept_s & (iIssue_Lat == {LATW{1'b0}});
        doneValid_s = iDone & busy_r;
    end

    // Per-register next state. Register 0 never holds state.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cntNext_s[r] = cnt_r[r];
            varNext_s[r] = var_r[r];
            if (r == 0) begin
                cntNext_s[r] = {LATW{1'b0}};
                varNext_s[r] = 1'b0;
            end else if (iFlush) begin
                cntNext_s[r] = {LATW{1'b0}};
                varNext_s[r] = 1'b0;
            end else begin
                if (acceptFix_s && (int'(iID_Rd) == r)) begin
                    cntNext_s[r] = iIssue_Lat;
                end else if (cnt_r[r] != {LATW{1'b0}}) begin
                    cntNext_s[r] = cnt_r[r] - {{(LATW-1){1'b0}}, 1'b1};
                end else begin
                    cntNext_s[r] = cnt_r[r];
                end
                // WAW stall keeps a same-cycle set and clear on different registers.
                if (acceptVar_s && (int'(iID_Rd) == r)) begin
                    varNext_s[r] = 1'b1;
                end else if (doneValid_s && (int'(iDone_Rd) == r)) begin
                    varNext_s[r] = 1'b0;
                end else begin
                    varNext_s[r] = var_r[r];
                end
            end
        end
    end

    // Unit busy survives a flush: the unit keeps executing until iDone.
    always_comb begin
        if (acceptVar_s) begin
            busyNext_s = 1'b1;
        end else if (iDone) begin
            busyNext_s = 1'b0;
        end else begin
            busyNext_s = busy_r;
        end
    end

    // Scoreboard state and stall counter registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= {LATW{1'b0}};
            end
            var_r        <= {NREG{1'b0}};
            busy_r       <= 1'b0;
            stallCount_r <= {CNTW{1'b0}};
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cntNext_s[r];
            end
            var_r  <= varNext_s;
            busy_r <= busyNext_s;
            if (stall_s && (stallCount_r != {CNTW{1'b1}})) begin
                stallCount_r <= stallCount_r + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                stallCount_r <= stallCount_r;
            end
        end
    end

    assign oStall      = stall_s;
    assign oPending    = pending_s;
    assign oUnitBusy   = busy_r;
    assign oStallCount = stallCount_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        iCLK;
    logic        iRST_n;
    logic [4:0]  iID_Rs1, iID_Rs2, iID_Rd, iDone_Rd;
    logic        iID_UseRs1, iID_UseRs2, iIssue, iDone, iFlush;
    logic [4:0]  iIssue_Lat;
    logic        oStall;
    logic [31:0] oPending;
    logic        oUnitBusy;
    logic [31:0] oStallCount;

    int nAsserts = 0;
    int nFails   = 0;

    // Reference model: each fixed-latency write is a timestamp (edge index at
    // which it retires); variable writes are a set of flagged registers.
    int          edges = 0;
    int          retireAt [32];
    bit          varSet   [32];
    bit          busyM    = 1'b0;
    logic [31:0] cntM     = 32'd0;
    logic [4:0]  lastVarRd = 5'd0;

    hazard_scoreboard dut (
        .iCLK(iCLK), .iRST_n(iRST_n),
        .iID_Rs1(iID_Rs1), .iID_Rs2(iID_Rs2),
        .iID_UseRs1(iID_UseRs1), .iID_UseRs2(iID_UseRs2),
        .iID_Rd(iID_Rd), .iIssue(iIssue), .iIssue_Lat(iIssue_Lat),
        .iDone(iDone), .iDone_Rd(iDone_Rd), .iFlush(iFlush),
        .oStall(oStall), .oPending(oPending), .oUnitBusy(oUnitBusy),
        .oStallCount(oStallCount)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend(input int r);
        return (r != 0) && ((edges < retireAt[r]) || varSet[r]);
    endfunction

    function automatic logic [31:0] pendVec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = pend(r);
        return v;
    endfunction

    function automatic bit modelStall();
        return (iID_UseRs1 && pend(int'(iID_Rs1)))
            || (iID_UseRs2 && pend(int'(iID_Rs2)))
            || (iIssue && iID_Rd != 5'd0 && pend(int'(iID_Rd)))
            || (iIssue && iIssue_Lat == 5'd0 && busyM && !iDone);
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            retireAt[r] = 0;
            varSet[r]   = 1'b0;
        end
        busyM = 1'b0;
        cntM  = 32'd0;
    endtask

    // Apply the rules at a rising edge using the inputs currently driven.
    task automatic modelEdge();
        bit s, acc;
        s   = modelStall();
        acc = iIssue && !s && !iFlush;
        if (s && cntM != 32'hFFFF_FFFF) cntM++;
        edges++;
        if (iFlush) begin
            for (int r = 0; r < 32; r++) begin
                retireAt[r] = 0;
                varSet[r]   = 1'b0;
            end
        end else begin
            if (iDone && busyM) varSet[iDone_Rd] = 1'b0;
            if (acc && iIssue_Lat != 5'd0 && iID_Rd != 5'd0) retireAt[iID_Rd] = edges + int'(iIssue_Lat);
            if (acc && iIssue_Lat == 5'd0 && iID_Rd != 5'd0) varSet[iID_Rd] = 1'b1;
        end
        if (acc && iIssue_Lat == 5'd0) begin
            busyM     = 1'b1;
            lastVarRd = iID_Rd;
        end else if (iDone) begin
            busyM = 1'b0;
        end
    endtask

    task automatic idle();
        iID_Rs1 = 5'd0; iID_Rs2 = 5'd0; iID_UseRs1 = 1'b0; iID_UseRs2 = 1'b0;
        iID_Rd = 5'd0; iIssue = 1'b0; iIssue_Lat = 5'd0;
        iDone = 1'b0; iDone_Rd = 5'd0; iFlush = 1'b0;
    endtask

    // Called at posedge+1: compare all outputs mid-cycle, then take the edge.
    task automatic tick(input string tag);
        #4;
        check({tag, "/stall"},   {63'd0, oStall},    {63'd0, modelStall()});
        check({tag, "/pending"}, {32'd0, oPending},  {32'd0, pendVec()});
        check({tag, "/busy"},    {63'd0, oUnitBusy}, {63'd0, busyM});
        check({tag, "/count"},   {32'd0, oStallCount}, {32'd0, cntM});
        @(posedge iCLK);
        modelEdge();
        #1;
    endtask

    initial begin
        modelReset();
        idle();
        iRST_n = 1'b0;
        #12;
        check("reset/stall",   {63'd0, oStall},      64'd0);
        check("reset/pending", {32'd0, oPending},    64'd0);
        check("reset/busy",    {63'd0, oUnitBusy},   64'd0);
        check("reset/count",   {32'd0, oStallCount}, 64'd0);
        iRST_n = 1'b1;
        @(posedge iCLK);
        modelEdge();
        #1;

        // RAW on a fixed-latency write of 3 cycles
        iIssue = 1'b1; iID_Rd = 5'd5; iIssue_Lat = 5'd3;
        tick("raw/issue");
        idle(); iID_UseRs1 = 1'b1; iID_Rs1 = 5'd5;
        #1;
        check("raw/pend5", {32'd0, oPending}, 64'h20);
        check("raw/stall1", {63'd0, oStall}, 64'd1);
        for (int i = 0; i < 3; i++) tick("raw/hold");
        #1;
        check("raw/released", {63'd0, oStall}, 64'd0);
        check("raw/count3", {32'd0, oStallCount}, 64'd3);
        check("raw/pendclr", {32'd0, oPending}, 64'd0);

        // Structural hazard on the variable-latency unit
        idle(); iIssue = 1'b1; iID_Rd = 5'd7; iIssue_Lat = 5'd0;
        tick("var/issue7");
        iID_Rd = 5'd8;
        for (int i = 0; i < 3; i++) tick("var/wait8");
        iDone = 1'b1; iDone_Rd = 5'd7;
        #1;
        check("var/donestall", {63'd0, oStall}, 64'd0);
        tick("var/done7");
        idle();
        #1;
        check("var/pend8", {32'd0, oPending}, 64'h100);
        check("var/busy", {63'd0, oUnitBusy}, 64'd1);
        iDone = 1'b1; iDone_Rd = 5'd8;
        tick("var/done8");
        idle();
        tick("var/idle");

        // Writes to register 0 are not tracked
        iIssue = 1'b1; iID_Rd = 5'd0; iIssue_Lat = 5'd4;
        tick("r0/issue");
        idle(); iID_UseRs1 = 1'b1; iID_Rs1 = 5'd0;
        #1;
        check("r0/pending", {32'd0, oPending}, 64'd0);
        check("r0/stall", {63'd0, oStall}, 64'd0);
        for (int i = 0; i < 3; i++) tick("r0/hold");

        // WAW stall, then flush drops it
        idle(); iIssue = 1'b1; iID_Rd = 5'd3; iIssue_Lat = 5'd10;
        tick("waw/issue");
        idle();
        tick("waw/gap"); tick("waw/gap");
        iIssue = 1'b1; iID_Rd = 5'd3; iIssue_Lat = 5'd2;
        tick("waw/stall"); tick("waw/stall");
        iFlush = 1'b1;
        #1;
        check("waw/stallflush", {63'd0, oStall}, 64'd1);
        tick("waw/flush");
        iFlush = 1'b0;
        #1;
        check("waw/pendclr", {32'd0, oPending}, 64'd0);
        check("waw/stalldrop", {63'd0, oStall}, 64'd0);
        idle();
        tick("waw/idle");

        // Flush keeps the unit busy until iDone
        iIssue = 1'b1; iID_Rd = 5'd9; iIssue_Lat = 5'd0;
        tick("fl/issue9");
        idle(); iFlush = 1'b1;
        tick("fl/flush");
        idle();
        #1;
        check("fl/pend9", {32'd0, oPending}, 64'd0);
        check("fl/busy", {63'd0, oUnitBusy}, 64'd1);
        iIssue = 1'b1; iID_Rd = 5'd10; iIssue_Lat = 5'd0;
        #1;
        check("fl/stall", {63'd0, oStall}, 64'd1);
        tick("fl/wait"); tick("fl/wait");
        idle(); iDone = 1'b1; iDone_Rd = 5'd9;
        tick("fl/done");
        idle();
        #1;
        check("fl/notbusy", {63'd0, oUnitBusy}, 64'd0);

        // Asynchronous reset with three entries pending
        iIssue = 1'b1; iID_Rd = 5'd1; iIssue_Lat = 5'd20; tick("ar/i1");
        iID_Rd = 5'd2; tick("ar/i2");
        iID_Rd = 5'd3; iIssue_Lat = 5'd0; tick("ar/i3");
        idle();
        #1;
        check("ar/pend3", {32'd0, oPending}, 64'hE);
        #2;
        iRST_n = 1'b0;
        #1;
        check("ar/pending", {32'd0, oPending}, 64'd0);
        check("ar/busy", {63'd0, oUnitBusy}, 64'd0);
        check("ar/count", {32'd0, oStallCount}, 64'd0);
        check("ar/stall", {63'd0, oStall}, 64'd0);
        modelReset();
        #2;
        iRST_n = 1'b1;
        @(posedge iCLK);
        modelEdge();
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            iID_Rs1    = 5'($urandom_range(0, 7));
            iID_Rs2    = 5'($urandom_range(0, 7));
            iID_UseRs1 = 1'($urandom_range(0, 1));
            iID_UseRs2 = 1'($urandom_range(0, 1));
            iIssue     = ($urandom_range(0, 2) == 0);
            iID_Rd     = 5'($urandom_range(0, 7));
            iIssue_Lat = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
            if ($urandom_range(0, 15) == 0) iIssue_Lat = 5'd31;
            if (iIssue_Lat == 5'd0 && iID_Rd == 5'd0) iID_Rd = 5'd1;
            if (busyM && $urandom_range(0, 3) == 0) begin
                iDone = 1'b1; iDone_Rd = lastVarRd;
            end else if ($urandom_range(0, 19) == 0) begin
                iDone = 1'b1; iDone_Rd = 5'($urandom_range(0, 7));
            end else begin
                iDone = 1'b0; iDone_Rd = 5'd0;
            end
            iFlush = ($urandom_range(0, 39) == 0);
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers tracked; register 0 is never tracked.
REQ-002 Parameter RW, default 5: register-index width, with RW = clog2(NREG).
REQ-003 Parameter LATW, default 5: fixed-latency counter width; maximum latency is 2^LATW-1.
REQ-004 Parameter CNTW, default 32: width of the stall performance counter.
REQ-005 iCLK  in  1: single clock, rising edge.
REQ-006 iRST_n  in  1: reset, asynchronous, active-low.
REQ-007 iID_Rs1, iID_Rs2  in  RW each: source registers of the instruction in ID.
REQ-008 iID_UseRs1, iID_UseRs2  in  1 each: the ID instruction reads that source.
REQ-009 iID_Rd  in  RW: destination register of the ID instruction.
REQ-010 iIssue  in  1: the ID instruction is a multi-cycle writer requesting issue this cycle.
REQ-011 iIssue_Lat  in  LATW: latency of the issuing instruction; 0 means variable latency (DIVREM/FPU class).
REQ-012 iDone, iDone_Rd  in  1, RW: the variable-latency unit completes and writes iDone_Rd this cycle.
REQ-013 iFlush  in  1: exception or pipeline flush.
REQ-014 oStall  out  1: the ID stage must stall this cycle.
REQ-015 oPending  out  NREG: bit r is 1 while register r has an outstanding write.
REQ-016 oUnitBusy  out  1: a variable-latency operation is outstanding.
REQ-017 oStallCount  out  CNTW: number of cycles in which oStall was asserted.

Function
REQ-018 Per-register state: cnt[r] (LATW bits) and var[r] (1 bit); pending[r] = (cnt[r] != 0) | var[r]; oPending = pending.
REQ-019 Bit 0 of oPending and all state for register 0 are constant 0; issue or done with Rd = 0 records nothing.
REQ-020 oStall is combinational and is the OR of the following terms:
- (iID_UseRs1 & pending[iID_Rs1])
- (iID_UseRs2 & pending[iID_Rs2])
- (iIssue & iID_Rd != 0 & pending[iID_Rd]) (WAW)
- (iIssue & iIssue_Lat == 0 & oUnitBusy & !iDone) (structural)
REQ-021 An issue is accepted when iIssue & !oStall & !iFlush at the rising edge.
REQ-022 Accepted issue with Lat L > 0 loads cnt[Rd] <= L. Pending is then high for exactly L cycles after that edge.
REQ-023 Accepted issue with Lat 0 sets var[Rd] <= 1 and unit busy <= 1.
REQ-024 Each cycle, every nonzero cnt[r] not being loaded decrements by 1 and stops at 0; there is no wrap.
REQ-025 iDone clears var[iDone_Rd] and clears unit busy.
REQ-026 iDone while unit busy = 0 is ignored.
REQ-027 Same cycle iDone plus accepted variable issue: the clear of var[iDone_Rd] and the set of var[iID_Rd] both take effect, and unit busy stays 1. The WAW term guarantees the two registers differ.
REQ-028 iFlush clears all cnt[] and var[] at the edge, and no issue is accepted that cycle.
REQ-029 iFlush does not clear unit busy, because the unit is still executing. A subsequent iDone clears it, and its var clear is harmless.
REQ-030 oStallCount increments by 1 on every edge where oStall = 1, saturating at 2^CNTW-1.
REQ-031 oStall does not depend on iFlush; the pipeline controller gives flush priority.

Reset
REQ-032 While iRST_n = 0, asynchronously: all cnt = 0, all var = 0, unit busy = 0, oStallCount = 0. Outputs are oStall = 0 (absent requests), oPending = 0, oUnitBusy = 0.
REQ-033 Reset asserted mid-operation discards all outstanding entries; the first edge after deassertion behaves as an empty scoreboard.

Verification
REQ-034 Issue Rd=5 with Lat=3, then hold ID Rs1=5 with UseRs1=1 -> oPending[5] high for 3 cycles, oStall=1 for those 3 cycles, then 0; oStallCount=3.
REQ-035 Issue Rd=7 with Lat=0, then request a second variable issue Rd=8 -> oStall=1 until iDone,Rd=7. In the iDone cycle oStall=0 and Rd=8 is accepted; afterwards oPending[7]=0, oPending[8]=1, oUnitBusy=1.
REQ-036 Issue Rd=0 with Lat=4 -> oPending stays all-zero and no stall is generated on Rs1=0.
REQ-037 Issue Rd=3 with Lat=10; after 2 cycles request an issue with Rd=3 -> WAW stall until cnt[3] reaches 0; iFlush at cycle 4 -> oPending=0 next cycle and the stall drops.
REQ-038 Variable issue Rd=9, then iFlush -> oPending[9]=0 and oUnitBusy stays 1; a variable issue is stalled until iDone, after which oUnitBusy=0.
REQ-039 Assert iRST_n=0 between clock edges while 3 entries are pending -> all outputs 0 immediately, without waiting for a clock edge.
